// File: rtl/droop_emu_16_if.sv
// droop_emu_16_if: trigger, sample and status bundle for droop_emu_16.
// master drives the trigger/sample/config side, slave is the emulator.
interface droop_emu_16_if #(
    parameter int WIN_W = 12
);
    logic                    trig;
    logic signed [15:0]      din;
    logic signed [6:0]       droopWeight;
    logic                    accClr_en;
    logic        [WIN_W-1:0] winLen;
    logic signed [15:0]      dout;
    logic                    oflowDetect;
    logic                    busy;

    modport master (
        output trig, din, droopWeight, accClr_en, winLen,
        input  dout, oflowDetect, busy
    );

    modport slave (
        input  trig, din, droopWeight, accClr_en, winLen,
        output dout, oflowDetect, busy
    );
endinterface

// File: rtl/droop_emu_16.sv
// droop_emu_16: emulates supply droop on a 16-bit signed sample stream.
// On a trigger edge a window of winLen cycles opens during which the output
// is fed back through droopWeight into a wide accumulator, and the scaled
// accumulator is subtracted from the delayed input.
// Optional feature macro: DROOP_SAT_EN (saturating output, sticky overflow).
module droop_emu_16 #(
    parameter int DROOP_SCALE = 15,
    parameter int WIN_W       = 12
) (
    input logic           clk,
    input logic           rst,
    droop_emu_16_if.slave bus
);

    typedef enum logic [1:0] {IDLE, ACTIVE, FLUSH} state_t;

    state_t             state_q, state_d;
    logic               trig_a_q, trig_a_d, trig_b_q, trig_b_d;
    logic               settle_q, settle_d, armed_q, armed_d;
    logic signed [6:0]  w_a_q, w_a_d, w_b_q, w_b_d;
    logic signed [15:0] din_del_q, din_del_d;
    logic signed [15:0] dout_q, dout_d;
    logic signed [22:0] prod_q, prod_d;
    logic signed [47:0] tap_q, tap_d;
    logic [WIN_W-1:0]   cnt_q, cnt_d;
    logic               oflow_q, oflow_d;

    logic               trig_edge;
    logic               acc_ovf;
    logic               win_ok;
    logic [WIN_W-1:0]   win_last;
    logic signed [15:0] tap_slice;
    logic signed [15:0] sub_res;
`ifdef DROOP_SAT_EN
    logic signed [16:0] sub;
    logic               sub_ovf;
`endif

    // Input synchronisers and edge arming. A trigger that is already high
    // when reset releases must be seen low once before an edge can count.
    always_comb begin
        trig_a_d  = bus.trig;
        trig_b_d  = trig_a_q;
        settle_d  = 1'b1;
        armed_d   = armed_q | (settle_q & ~trig_a_q);
        w_a_d     = bus.droopWeight;
        w_b_d     = w_a_q;
        din_del_d = bus.din;
    end

    // Datapath helpers: edge, window reload value, scaled tap and subtraction.
    always_comb begin
        trig_edge = armed_q & trig_a_q & ~trig_b_q;
        win_ok    = |bus.winLen;
        win_last  = bus.winLen - WIN_W'(1);
        tap_slice = tap_q[DROOP_SCALE+15:DROOP_SCALE];
        acc_ovf   = tap_q[DROOP_SCALE+16] ^ tap_q[DROOP_SCALE+15];
`ifdef DROOP_SAT_EN
        sub     = {din_del_q[15], din_del_q} - {tap_slice[15], tap_slice};
        sub_ovf = sub[16] ^ sub[15];
        if (sub_ovf) sub_res = sub[16] ? 16'sh8000 : 16'sh7fff;
        else         sub_res = sub[15:0];
`else
        // Low 16 bits of the 17-bit difference: plain wrap.
        sub_res = din_del_q - tap_slice;
`endif
    end

    // Window FSM with accumulator, product and output updates.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tap_d   = tap_q;
        prod_d  = prod_q;
        dout_d  = dout_q;
        unique case (state_q)
            IDLE: begin
                tap_d  = '0;
                prod_d = '0;
                dout_d = din_del_q;
                if (trig_edge && win_ok) begin
                    state_d = ACTIVE;
                    cnt_d   = win_last;
                end
            end
            ACTIVE: begin
                prod_d = 23'(dout_q) * 23'(w_b_q);
                tap_d  = tap_q + 48'(prod_q);
                dout_d = sub_res;
                if (trig_edge && bus.accClr_en && win_ok) begin
                    // restart: drop the accumulated droop, reopen the window
                    tap_d  = '0;
                    prod_d = '0;
                    cnt_d  = win_last;
                end else if (cnt_q == '0) begin
                    state_d = FLUSH;
                end else begin
                    cnt_d = cnt_q - WIN_W'(1);
                end
            end
            FLUSH: begin
                tap_d   = '0;
                prod_d  = '0;
                dout_d  = din_del_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Overflow flag: sticky across a window when saturating, else a live
    // registered copy of the accumulator overflow test.
    always_comb begin
`ifdef DROOP_SAT_EN
        if (state_q == IDLE && state_d == ACTIVE)
            oflow_d = 1'b0;
        else
            oflow_d = oflow_q | acc_ovf | ((state_q == ACTIVE) & sub_ovf);
`else
        oflow_d = acc_ovf;
`endif
    end

    // State register; reset wins over everything else.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            trig_a_q  <= 1'b0;
            trig_b_q  <= 1'b0;
            settle_q  <= 1'b0;
            armed_q   <= 1'b0;
            w_a_q     <= '0;
            w_b_q     <= '0;
            din_del_q <= '0;
            dout_q    <= '0;
            prod_q    <= '0;
            tap_q     <= '0;
            cnt_q     <= '0;
            oflow_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            trig_a_q  <= trig_a_d;
            trig_b_q  <= trig_b_d;
            settle_q  <= settle_d;
            armed_q   <= armed_d;
            w_a_q     <= w_a_d;
            w_b_q     <= w_b_d;
            din_del_q <= din_del_d;
            dout_q    <= dout_d;
            prod_q    <= prod_d;
            tap_q     <= tap_d;
            cnt_q     <= cnt_d;
            oflow_q   <= oflow_d;
        end
    end

    assign bus.dout        = dout_q;
    assign bus.oflowDetect = oflow_q;
    assign bus.busy        = (state_q == ACTIVE);

endmodule
